// File: rtl/add_1_bit.sv
// One-bit full adder stage for ripple-carry chains.
// Exposes carry-generate/propagate for lookahead use and, optionally,
// registered copies of sum and carry out. The combinational path never
// touches clk or rst, so positional five-port ripple instantiations that
// leave the clock and reset open keep working.
module add_1_bit #(
  parameter int unsigned REGISTERED = 0
) (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout,
  input  logic clk,
  input  logic rst,
  output logic gen,
  output logic prop,
  output logic sum_q,
  output logic cout_q
);

  // Carry generate/propagate and the sum/carry built from them; plain
  // operators so X/Z on any input shows up as X on the affected outputs.
  always_comb begin
    gen  = a & b;
    prop = a ^ b;
    sum  = prop ^ cin;
    cout = gen | (prop & cin);
  end

  if (REGISTERED != 0) begin : g_reg
    // Registered copies, one cycle behind; synchronous reset takes priority
    // over whatever inputs arrive on the same edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q  <= 1'b0;
        cout_q <= 1'b0;
      end else begin
        sum_q  <= sum;
        cout_q <= cout;
      end
    end
  end else begin : g_noreg
    // No flops in this build: registered outputs tie low, clock and reset
    // are intentionally left without a load.
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst};
    assign sum_q  = 1'b0;
    assign cout_q = 1'b0;
  end

endmodule

// File: tb/tb_add_1_bit.sv
// Directed bench for add_1_bit: exhaustive truth table, a 5-stage ripple
// chain, the registered path with reset, and the unregistered build.
module tb_add_1_bit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a = 1'b0, b = 1'b0, cin = 1'b0;

  logic sum_r, cout_r, gen_r, prop_r, sum_q_r, cout_q_r;
  logic sum_u, cout_u, gen_u, prop_u, sum_q_u, cout_q_u;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] exp_cs [8];
  logic [7:0] exp_gen;
  logic [7:0] exp_prop;

  // Clock generator
  always #5 clk = ~clk;

  add_1_bit #(.REGISTERED(1)) dut_r (
    .a(a), .b(b), .cin(cin), .sum(sum_r), .cout(cout_r),
    .clk(clk), .rst(rst), .gen(gen_r), .prop(prop_r),
    .sum_q(sum_q_r), .cout_q(cout_q_r)
  );

  add_1_bit #(.REGISTERED(0)) dut_u (
    .a(a), .b(b), .cin(cin), .sum(sum_u), .cout(cout_u),
    .clk(clk), .rst(rst), .gen(gen_u), .prop(prop_u),
    .sum_q(sum_q_u), .cout_q(cout_q_u)
  );

  // Five-stage ripple chain on zero-extended 4-bit operands
  logic [3:0] in1 = 4'h0, in2 = 4'h0;
  logic [4:0] op1, op2, res;
  logic [5:0] carry;
  logic [4:0] cg_gen, cg_prop, cg_sq, cg_cq;
  logic       chain_clk = 1'b0;
  logic       chain_rst = 1'b0;
  assign op1 = {1'b0, in1};
  assign op2 = {1'b0, in2};
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 5; i++) begin : g_chain
    add_1_bit stage (
      .a(op1[i]), .b(op2[i]), .cin(carry[i]), .sum(res[i]), .cout(carry[i+1]),
      .clk(chain_clk), .rst(chain_rst), .gen(cg_gen[i]), .prop(cg_prop[i]),
      .sum_q(cg_sq[i]), .cout_q(cg_cq[i])
    );
  end

  task automatic test_exhaustive();
    for (int i = 0; i < 8; i++) begin
      {a, b, cin} = 3'(i);
      #1;
      n_cmp++;
      if ({cout_r, sum_r} !== exp_cs[i]) begin
        n_err++;
        $display("FAIL exhaustive_r abc=%0d got %b%b want %b", i, cout_r, sum_r, exp_cs[i]);
      end
      n_cmp++;
      if ({cout_u, sum_u} !== exp_cs[i]) begin
        n_err++;
        $display("FAIL exhaustive_u abc=%0d got %b%b want %b", i, cout_u, sum_u, exp_cs[i]);
      end
      n_cmp++;
      if (gen_r !== exp_gen[i] || gen_u !== exp_gen[i]) begin
        n_err++;
        $display("FAIL gen abc=%0d got %b/%b want %b", i, gen_r, gen_u, exp_gen[i]);
      end
      n_cmp++;
      if (prop_r !== exp_prop[i] || prop_u !== exp_prop[i]) begin
        n_err++;
        $display("FAIL prop abc=%0d got %b/%b want %b", i, prop_r, prop_u, exp_prop[i]);
      end
    end
  endtask

  task automatic test_ripple();
    logic [5:0] want;
    in1 = 4'hF;
    in2 = 4'h1;
    #1;
    n_cmp++;
    if ({carry[5], res} !== 6'h10) begin
      n_err++;
      $display("FAIL ripple_f_1 got %h want 10", {carry[5], res});
    end
    for (int k = 0; k < 32; k++) begin
      in1 = 4'($urandom_range(15, 0));
      in2 = 4'($urandom_range(15, 0));
      want = 6'(in1) + 6'(in2);
      #1;
      n_cmp++;
      if ({carry[5], res} !== want) begin
        n_err++;
        $display("FAIL ripple_rand %h+%h got %h want %h", in1, in2, {carry[5], res}, want);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    {a, b, cin} = 3'b111;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++;
    if (sum_q_r !== 1'b0 || cout_q_r !== 1'b0) begin
      n_err++;
      $display("FAIL reset_q got %b%b want 00", cout_q_r, sum_q_r);
    end
    n_cmp++;
    if (sum_r !== 1'b1 || cout_r !== 1'b1) begin
      n_err++;
      $display("FAIL reset_comb got %b%b want 11", cout_r, sum_r);
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    rst = 1'b0;
    {a, b, cin} = 3'b111;
    #1;
    n_cmp++;
    if (sum_q_r !== 1'b0 || cout_q_r !== 1'b0) begin
      n_err++;
      $display("FAIL reg_before_edge got %b%b want 00", cout_q_r, sum_q_r);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (sum_q_r !== 1'b1 || cout_q_r !== 1'b1) begin
      n_err++;
      $display("FAIL reg_one_edge got %b%b want 11", cout_q_r, sum_q_r);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst = 1'b1;
    {a, b, cin} = 3'b100;
    #1;
    n_cmp++;
    if (sum_r !== 1'b1 || sum_q_r !== 1'b1) begin
      n_err++;
      $display("FAIL mid_before got sum=%b sum_q=%b want 1 1", sum_r, sum_q_r);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (sum_q_r !== 1'b0 || cout_q_r !== 1'b0 || sum_r !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset got q=%b%b sum=%b want q=00 sum=1", cout_q_r, sum_q_r, sum_r);
    end
    @(negedge clk);
    rst = 1'b0;
    {a, b, cin} = 3'b110;
    @(posedge clk);
    #1;
    n_cmp++;
    if (sum_q_r !== 1'b0 || cout_q_r !== 1'b1) begin
      n_err++;
      $display("FAIL mid_release got %b%b want 10", cout_q_r, sum_q_r);
    end
  endtask

  task automatic test_back_to_back();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {a, b, cin} = 3'(7 - i);
      @(posedge clk);
      #1;
      n_cmp++;
      if ({cout_q_r, sum_q_r} !== exp_cs[7-i]) begin
        n_err++;
        $display("FAIL b2b abc=%0d got %b%b want %b", 7 - i, cout_q_r, sum_q_r, exp_cs[7-i]);
      end
    end
  endtask

  task automatic test_unregistered();
    logic [2:0] v;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v = 3'($urandom_range(7, 0));
      {a, b, cin} = v;
      rst = 1'($urandom_range(1, 0));
      @(posedge clk);
      #1;
      n_cmp++;
      if (sum_q_u !== 1'b0 || cout_q_u !== 1'b0) begin
        n_err++;
        $display("FAIL unreg_q abc=%0d rst=%b got %b%b want 00", v, rst, cout_q_u, sum_q_u);
      end
      n_cmp++;
      if ({cout_u, sum_u} !== exp_cs[v]) begin
        n_err++;
        $display("FAIL unreg_comb abc=%0d got %b%b want %b", v, cout_u, sum_u, exp_cs[v]);
      end
    end
    rst = 1'b0;
  endtask

  // Test sequence
  initial begin
    exp_cs   = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    exp_gen  = 8'b1100_0000;
    exp_prop = 8'b0011_1100;
    test_reset();
    test_exhaustive();
    test_ripple();
    test_registered();
    test_reset_mid();
    test_back_to_back();
    test_unregistered();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
